// File: rtl/stump_control_pkg.sv
// Shared Stump control definitions: state encodings, opcodes, immediate
// selects and condition-code numbers used by the control unit.
package stump_control_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADC  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SBC  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_LDST = 3'd6;
    localparam logic [2:0] OP_BCC  = 3'd7;

    localparam logic [1:0] EXT_IMM5 = 2'b00;
    localparam logic [1:0] EXT_IMM8 = 2'b01;
    localparam logic [1:0] EXT_ONE  = 2'b10;

    localparam logic [2:0] REG_PC = 3'd7;

    localparam logic [3:0] COND_AL = 4'h0;
    localparam logic [3:0] COND_NV = 4'h1;
    localparam logic [3:0] COND_HI = 4'h2;
    localparam logic [3:0] COND_LS = 4'h3;
    localparam logic [3:0] COND_CC = 4'h4;
    localparam logic [3:0] COND_CS = 4'h5;
    localparam logic [3:0] COND_NE = 4'h6;
    localparam logic [3:0] COND_EQ = 4'h7;
    localparam logic [3:0] COND_VC = 4'h8;
    localparam logic [3:0] COND_VS = 4'h9;
    localparam logic [3:0] COND_PL = 4'hA;
    localparam logic [3:0] COND_MI = 4'hB;
    localparam logic [3:0] COND_GE = 4'hC;
    localparam logic [3:0] COND_LT = 4'hD;
    localparam logic [3:0] COND_GT = 4'hE;
    localparam logic [3:0] COND_LE = 4'hF;

    function automatic logic is_alu_op(input logic [2:0] op);
        return op < OP_LDST;
    endfunction

endpackage

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: decides whether a Bcc is taken from the
// 4-bit condition field and the current {N,Z,V,C} register.
module stump_cond_eval
    import stump_control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       taken
);

    logic n, z, v, c;

    always_comb begin
        n = cc[3];
        z = cc[2];
        v = cc[1];
        c = cc[0];
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            COND_HI: taken = ~c & ~z;
            COND_LS: taken = c | z;
            COND_CC: taken = ~c;
            COND_CS: taken = c;
            COND_NE: taken = ~z;
            COND_EQ: taken = z;
            COND_VC: taken = ~v;
            COND_VS: taken = v;
            COND_PL: taken = ~n;
            COND_MI: taken = n;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer, instruction decode
// and the NZVC condition-code register feeding the ALU carry-in.
//
// state      | meaning
// FETCH      | read instruction, load IR, PC <= PC + 1
// EXECUTE    | ALU op, address computation, or branch target write to PC
// MEMORY     | load writeback or store strobe (LD/ST only)
// ILLEGAL    | unreachable encoding, recovers to FETCH
module stump_control
    import stump_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags_in,
    output logic        fetch,
    output logic        execute,
    output logic        memory,
    output logic        ir_load,
    output logic [2:0]  alu_func,
    output logic        c_in,
    output logic [1:0]  shift_op,
    output logic        opB_mux_sel,
    output logic [1:0]  ext_op,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [2:0]  srcC,
    output logic [2:0]  dest,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  cc
);

    state_t     state;
    logic [2:0] op;
    logic       imm_form;
    logic       s_bit;
    logic [2:0] rd, ra, rb;
    logic [1:0] shift;
    logic [3:0] cond;
    logic       taken;
    logic       ir_load_raw, reg_write_raw, mem_ren_raw, mem_wen_raw;

    assign op       = ir[15:13];
    assign imm_form = ir[12];
    assign s_bit    = ir[11];
    assign rd       = ir[10:8];
    assign ra       = ir[7:5];
    assign shift    = ir[4:3];
    assign rb       = ir[2:0];
    assign cond     = ir[11:8];

    stump_cond_eval u_cond_eval (
        .cond  (cond),
        .cc    (cc),
        .taken (taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
            cc    <= 4'b0000;
        end else begin
            case (state)
                ST_FETCH:   state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    state <= (op == OP_LDST) ? ST_MEMORY : ST_FETCH;
                    if (is_alu_op(op) && s_bit)
                        cc <= flags_in;
                end
                ST_MEMORY:  state <= ST_FETCH;
                default:    state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        fetch         = (state == ST_FETCH);
        execute       = (state == ST_EXECUTE);
        memory        = (state == ST_MEMORY);
        ir_load_raw   = 1'b0;
        alu_func      = OP_ADD;
        shift_op      = 2'b00;
        opB_mux_sel   = 1'b0;
        ext_op        = EXT_IMM5;
        srcA          = 3'd0;
        srcB          = 3'd0;
        srcC          = rd;
        dest          = 3'd0;
        reg_write_raw = 1'b0;
        wb_sel        = 1'b0;
        mem_ren_raw   = 1'b0;
        mem_wen_raw   = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_ren_raw   = 1'b1;
                ir_load_raw   = 1'b1;
                srcA          = REG_PC;
                opB_mux_sel   = 1'b1;
                ext_op        = EXT_ONE;
                dest          = REG_PC;
                reg_write_raw = 1'b1;
            end
            ST_EXECUTE: begin
                if (op == OP_BCC) begin
                    srcA          = REG_PC;
                    opB_mux_sel   = 1'b1;
                    ext_op        = EXT_IMM8;
                    dest          = REG_PC;
                    reg_write_raw = taken;
                end else begin
                    // LD/ST reuses the ALU operand path as an ADD for the address
                    srcA = ra;
                    if (is_alu_op(op)) begin
                        alu_func      = op;
                        dest          = rd;
                        reg_write_raw = 1'b1;
                    end
                    if (imm_form) begin
                        opB_mux_sel = 1'b1;
                    end else begin
                        srcB = rb;
                        if (is_alu_op(op))
                            shift_op = shift;
                    end
                end
            end
            ST_MEMORY: begin
                if (s_bit) begin
                    mem_wen_raw = 1'b1;
                end else begin
                    mem_ren_raw   = 1'b1;
                    reg_write_raw = 1'b1;
                    dest          = rd;
                    wb_sel        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign c_in      = cc[0];
    assign ir_load   = ir_load_raw & ~rst;
    assign reg_write = reg_write_raw & ~rst;
    assign mem_ren   = mem_ren_raw & ~rst;
    assign mem_wen   = mem_wen_raw & ~rst;

endmodule

// File: tb/tb_stump_control.sv
// Directed bench for stump_control: vector table of single instructions,
// branch-condition sweeps and reset-abort sequences.
module tb_stump_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  flags_in;
    logic        fetch, execute, memory, ir_load, c_in, opB_mux_sel;
    logic        reg_write, wb_sel, mem_ren, mem_wen;
    logic [2:0]  alu_func, srcA, srcB, srcC, dest;
    logic [1:0]  shift_op, ext_op;
    logic [3:0]  cc;

    int unsigned checks = 0;
    int unsigned errors = 0;

    stump_control dut (
        .clk(clk), .rst(rst), .ir(ir), .flags_in(flags_in),
        .fetch(fetch), .execute(execute), .memory(memory), .ir_load(ir_load),
        .alu_func(alu_func), .c_in(c_in), .shift_op(shift_op),
        .opB_mux_sel(opB_mux_sel), .ext_op(ext_op), .srcA(srcA), .srcB(srcB),
        .srcC(srcC), .dest(dest), .reg_write(reg_write), .wb_sel(wb_sel),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .cc(cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cc_pre;
        logic [15:0] ir;
        logic [3:0]  flags;
        logic [2:0]  alu;
        logic        c_in;
        logic [2:0]  srca;
        logic [2:0]  srcb;
        logic [1:0]  shift;
        logic        opb;
        logic [1:0]  ext;
        logic [2:0]  dest;
        logic        rw;
        logic [3:0]  cc_post;
        logic        m_ren;
        logic        m_wen;
        logic        m_rw;
        logic        m_wb;
        logic [2:0]  m_dest;
        logic [2:0]  m_srcc;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // {fetch,execute,memory,ir_load,mem_ren,mem_wen,reg_write,wb_sel,alu,opb,ext,srcA,dest}
    task automatic chk_fetch(input string nm, input logic strobes_on);
        chk(nm, {fetch, execute, memory, ir_load, mem_ren, mem_wen, reg_write, wb_sel,
                 alu_func, opB_mux_sel, ext_op, srcA, dest},
            {1'b1, 1'b0, 1'b0, strobes_on, strobes_on, 1'b0, strobes_on, 1'b0,
             3'd0, 1'b1, 2'b10, 3'd7, 3'd7});
    endtask

    // Runs a flag-setting ADD so cc takes the given value; starts and ends in FETCH.
    task automatic set_cc(input logic [3:0] v);
        ir = 16'h0800;
        flags_in = v;
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        set_cc(v.cc_pre);
        chk($sformatf("v%0d cc_pre", idx), cc, v.cc_pre);
        ir = v.ir;
        flags_in = v.flags;
        #1;
        chk_fetch($sformatf("v%0d fetch", idx), 1'b1);
        @(negedge clk); #1;
        chk($sformatf("v%0d exec_state", idx), {fetch, execute, memory}, 3'b010);
        chk($sformatf("v%0d exec_decode", idx),
            {alu_func, c_in, srcA, srcB, shift_op, opB_mux_sel, ext_op, dest, reg_write},
            {v.alu, v.c_in, v.srca, v.srcb, v.shift, v.opb, v.ext, v.dest, v.rw});
        chk($sformatf("v%0d exec_strobes", idx), {ir_load, mem_ren, mem_wen, wb_sel}, 4'b0000);
        @(negedge clk); #1;
        if (v.ir[15:13] == 3'b110) begin
            chk($sformatf("v%0d mem_state", idx), {fetch, execute, memory}, 3'b001);
            chk($sformatf("v%0d mem_decode", idx),
                {mem_ren, mem_wen, reg_write, wb_sel, dest, srcC},
                {v.m_ren, v.m_wen, v.m_rw, v.m_wb, v.m_dest, v.m_srcc});
            @(negedge clk); #1;
        end
        chk($sformatf("v%0d back_to_fetch", idx), {fetch, execute, memory}, 3'b100);
        chk($sformatf("v%0d cc_post", idx), cc, v.cc_post);
    endtask

    task automatic branch_sweep(input logic [3:0] ccv, input logic [15:0] mask);
        set_cc(ccv);
        for (int c = 0; c < 16; c++) begin
            ir = {3'b111, 1'b0, c[3:0], 8'h05};
            flags_in = ~ccv;
            #1;
            chk_fetch($sformatf("br cc=%b cond=%0d fetch", ccv, c), 1'b1);
            @(negedge clk); #1;
            chk($sformatf("br cc=%b cond=%0d exec", ccv, c),
                {execute, srcA, opB_mux_sel, ext_op, alu_func, dest, reg_write},
                {1'b1, 3'd7, 1'b1, 2'b01, 3'd0, 3'd7, mask[c]});
            @(negedge clk); #1;
            chk($sformatf("br cc=%b cond=%0d cc_hold", ccv, c), cc, ccv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b0000, 16'h0A2B, 4'b0101, 3'd0, 1'b0, 3'd1, 3'd3, 2'd1, 1'b0, 2'd0, 3'd2, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[1]  = '{4'b0001, 16'h3A3F, 4'b0110, 3'd1, 1'b1, 3'd1, 3'd0, 2'd0, 1'b1, 2'd0, 3'd2, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[2]  = '{4'b0001, 16'h323F, 4'b1000, 3'd1, 1'b1, 3'd1, 3'd0, 2'd0, 1'b1, 2'd0, 3'd2, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[3]  = '{4'b1111, 16'h4DD4, 4'b0011, 3'd2, 1'b1, 3'd6, 3'd4, 2'd2, 1'b0, 2'd0, 3'd5, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[4]  = '{4'b0000, 16'h9387, 4'b1111, 3'd4, 1'b0, 3'd4, 3'd0, 2'd0, 1'b1, 2'd0, 3'd3, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[5]  = '{4'b0010, 16'hAF19, 4'b1100, 3'd5, 1'b0, 3'd0, 3'd1, 2'd3, 1'b0, 2'd0, 3'd7, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[6]  = '{4'b0101, 16'h78E1, 4'b1001, 3'd3, 1'b1, 3'd7, 3'd0, 2'd0, 1'b1, 2'd0, 3'd0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[7]  = '{4'b0011, 16'hC245, 4'b1111, 3'd0, 1'b1, 3'd2, 3'd5, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 3'd2};
        vecs[8]  = '{4'b0000, 16'hCB3F, 4'b1111, 3'd0, 1'b0, 3'd1, 3'd7, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd3};
        vecs[9]  = '{4'b1000, 16'hDCC2, 4'b0111, 3'd0, 1'b0, 3'd6, 3'd0, 2'd0, 1'b1, 2'd0, 3'd0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4};
        vecs[10] = '{4'b0100, 16'hE705, 4'b0000, 3'd0, 1'b0, 3'd7, 3'd0, 2'd0, 1'b1, 2'd1, 3'd7, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};

        rst = 1'b1;
        ir = 16'h0000;
        flags_in = 4'b0000;
        #1;
        chk("reset cc", cc, 4'b0000);
        chk_fetch("reset outputs", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_fetch("post-reset fetch", 1'b1);

        for (int i = 0; i < 11; i++)
            run_vec(i);

        branch_sweep(4'b0100, 16'h9599);
        branch_sweep(4'b1010, 16'h5A55);
        branch_sweep(4'b1000, 16'hA955);

        // Short reset pulse inside EXECUTE of a flag-setting ADD
        set_cc(4'b0011);
        ir = 16'h0A2B;
        flags_in = 4'b0101;
        @(negedge clk); #1;
        chk("abort pre exec", {execute, reg_write}, 2'b11);
        rst = 1'b1;
        #1;
        chk("abort cc cleared", cc, 4'b0000);
        chk_fetch("abort in reset", 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort next edge state", {fetch, execute, memory}, 3'b010);
        chk("abort next edge cc", cc, 4'b0000);
        @(posedge clk); #1;
        chk("abort rerun cc", cc, 4'b0101);
        @(negedge clk); #1;

        // Reset held across an edge during a load's MEMORY cycle
        ir = 16'hC245;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mem abort pre", {memory, mem_ren, reg_write}, 3'b111);
        rst = 1'b1;
        #1;
        chk("mem abort strobes", {mem_ren, mem_wen, reg_write, ir_load, fetch}, 5'b00001);
        @(posedge clk); #1;
        chk("mem abort held", {fetch, reg_write, mem_ren, cc}, {1'b1, 1'b0, 1'b0, 4'b0000});
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_fetch("mem abort release", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
